// File: rtl/plru_replacement_unit.sv
// Tree pseudo-LRU replacement state for a set-associative cache: one tree per set,
// registered one-hot victim selection (invalid ways first) and a set-by-set flush sweep.
module plru_replacement_unit #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16,
    localparam int SET_IDX_WIDTH = $clog2(NUM_SETS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_query_valid,
    input  logic [SET_IDX_WIDTH-1:0] i_query_set,
    input  logic [NUM_WAYS-1:0]      i_query_valid_bits,
    output logic [NUM_WAYS-1:0]      o_victim_mask,
    output logic                     o_victim_valid,
    input  logic                     i_touch_valid,
    input  logic [SET_IDX_WIDTH-1:0] i_touch_set,
    input  logic [NUM_WAYS-1:0]      i_touch_way_mask,
    input  logic                     i_flush,
    output logic                     o_busy,
    output logic                     o_dbg_state
);
    localparam int LEVELS = $clog2(NUM_WAYS);
    localparam int NODES  = NUM_WAYS - 1;
    localparam logic [SET_IDX_WIDTH-1:0] LAST_SET = SET_IDX_WIDTH'(NUM_SETS - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    // Handshake: i_query_valid / i_touch_valid are single-cycle strobes with no ready;
    // they are taken whenever the unit is idle or on the final flush cycle, and dropped
    // otherwise. o_busy tells the requester when strobes would be dropped.
    state_t                           r_state;
    state_t                           w_state_next;
    logic [SET_IDX_WIDTH-1:0]         r_cnt;
    logic [NUM_SETS-1:0][NODES-1:0]   r_tree;
    logic [NUM_WAYS-1:0]              r_victim_mask;
    logic                             r_victim_valid;

    logic                w_last;
    logic                w_accept;
    logic [NODES-1:0]    w_q_tree;
    logic [LEVELS-1:0]   w_walk_idx;
    logic [LEVELS-1:0]   w_inv_idx;
    logic [LEVELS-1:0]   w_victim_idx;
    logic [NUM_WAYS-1:0] w_victim_mask;
    logic [LEVELS-1:0]   w_t_idx;
    logic [NODES-1:0]    w_t_base;
    logic [NODES-1:0]    w_t_tree;
    logic                w_t_ok;
    logic                w_q_ok;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_flush) w_state_next = ST_FLUSH;
            ST_FLUSH: if (r_cnt == LAST_SET) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_last   = (r_state == ST_FLUSH) && (r_cnt == LAST_SET);
    assign w_accept = (r_state == ST_IDLE) || w_last;
    assign w_q_ok   = i_query_valid && w_accept;
    assign w_t_ok   = i_touch_valid && $onehot(i_touch_way_mask) && w_accept;

    // On the final flush cycle the set being cleared must be seen as already zero.
    assign w_q_tree = (w_last && (i_query_set == r_cnt)) ? '0 : r_tree[i_query_set];
    assign w_t_base = (w_last && (i_touch_set == r_cnt)) ? '0 : r_tree[i_touch_set];

    // Path bits collected root-first form the way index directly.
    always_comb begin
        int p;
        p = 0;
        for (int l = 0; l < LEVELS; l++) begin
            p = 2 * p + int'(w_q_tree[(1 << l) - 1 + p]);
        end
        w_walk_idx = p[LEVELS-1:0];
    end

    always_comb begin
        w_inv_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!i_query_valid_bits[i]) w_inv_idx = LEVELS'(i);
        end
    end

    assign w_victim_idx  = (&i_query_valid_bits) ? w_walk_idx : w_inv_idx;
    assign w_victim_mask = NUM_WAYS'(1) << w_victim_idx;

    always_comb begin
        w_t_idx = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (i_touch_way_mask[i]) w_t_idx = LEVELS'(i);
        end
    end

    // Each node on the path points at the half the touched way is not in.
    always_comb begin
        w_t_tree = w_t_base;
        for (int l = 0; l < LEVELS; l++) begin
            w_t_tree[(1 << l) - 1 + int'(w_t_idx >> (LEVELS - l))] = ~w_t_idx[LEVELS-1-l];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_tree         <= '0;
            r_victim_valid <= 1'b0;
            r_victim_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_FLUSH) begin
                r_tree[r_cnt] <= '0;
                r_cnt         <= r_cnt + SET_IDX_WIDTH'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_t_ok) r_tree[i_touch_set] <= w_t_tree;
            r_victim_valid <= w_q_ok;
            r_victim_mask  <= w_q_ok ? w_victim_mask : '0;
        end
    end

    assign o_victim_valid = r_victim_valid;
    assign o_victim_mask  = r_victim_mask;
    assign o_busy         = (r_state == ST_FLUSH);
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_plru_replacement_unit.sv
// Directed bench for plru_replacement_unit (4 ways, 16 sets): one task per scenario,
// each comparing DUT outputs against hand-computed values.
module tb_plru_replacement_unit;
    logic       clk;
    logic       rst;
    logic       q_valid;
    logic [3:0] q_set;
    logic [3:0] q_bits;
    logic [3:0] victim_mask;
    logic       victim_valid;
    logic       t_valid;
    logic [3:0] t_set;
    logic [3:0] t_mask;
    logic       flush;
    logic       busy;
    logic       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    plru_replacement_unit #(.NUM_WAYS(4), .NUM_SETS(16)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_query_valid      (q_valid),
        .i_query_set        (q_set),
        .i_query_valid_bits (q_bits),
        .o_victim_mask      (victim_mask),
        .o_victim_valid     (victim_valid),
        .i_touch_valid      (t_valid),
        .i_touch_set        (t_set),
        .i_touch_way_mask   (t_mask),
        .i_flush            (flush),
        .o_busy             (busy),
        .o_dbg_state        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: inputs change on the falling edge, outputs are captured 1ns after the rising edge.
    task automatic query(input logic [3:0] set, input logic [3:0] bits,
                         output logic vv, output logic [3:0] vm);
        @(negedge clk);
        q_valid = 1'b1; q_set = set; q_bits = bits;
        @(posedge clk); #1;
        vv = victim_valid; vm = victim_mask;
        q_valid = 1'b0;
    endtask

    task automatic touch(input logic [3:0] set, input logic [3:0] mask);
        @(negedge clk);
        t_valid = 1'b1; t_set = set; t_mask = mask;
        @(posedge clk); #1;
        t_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic vv; logic [3:0] vm;
        n_checks++;
        if (busy !== 1'b0 || victim_valid !== 1'b0 || victim_mask !== 4'b0000 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b vv=%b vm=%b st=%b, required 0 0 0000 0",
                     busy, victim_valid, victim_mask, dbg_state);
        end
        query(4'd0, 4'b1111, vv, vm);
        n_checks++;
        if (vv !== 1'b1 || vm !== 4'b0001) begin
            n_fail++; $display("FAIL reset_query: vv=%b vm=%b, required 1 0001", vv, vm);
        end
        @(posedge clk); #1;
        n_checks++;
        if (victim_valid !== 1'b0 || victim_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL query_idle_return: vv=%b vm=%b, required 0 0000", victim_valid, victim_mask);
        end
    endtask

    task automatic test_tree_walk();
        logic vv; logic [3:0] vm;
        touch(4'd3, 4'b0001);
        touch(4'd3, 4'b0100);
        touch(4'd3, 4'b0010);
        query(4'd3, 4'b1111, vv, vm);
        n_checks++;
        if (vv !== 1'b1 || vm !== 4'b1000) begin
            n_fail++; $display("FAIL walk_set3: vv=%b vm=%b, required 1 1000", vv, vm);
        end
        query(4'd4, 4'b1111, vv, vm);
        n_checks++;
        if (vm !== 4'b0001) begin
            n_fail++; $display("FAIL walk_set4_independent: vm=%b, required 0001", vm);
        end
        // Back-to-back queries on one set: both answered, one per cycle.
        @(negedge clk);
        q_valid = 1'b1; q_set = 4'd3; q_bits = 4'b1111;
        @(posedge clk); #1;
        n_checks++;
        if (victim_mask !== 4'b1000) begin
            n_fail++; $display("FAIL back_to_back_first: vm=%b, required 1000", victim_mask);
        end
        q_bits = 4'b1110;
        @(posedge clk); #1;
        q_valid = 1'b0;
        n_checks++;
        if (victim_valid !== 1'b1 || victim_mask !== 4'b0001) begin
            n_fail++; $display("FAIL back_to_back_second: vv=%b vm=%b, required 1 0001", victim_valid, victim_mask);
        end
    endtask

    task automatic test_invalid_first();
        logic vv; logic [3:0] vm;
        query(4'd3, 4'b1011, vv, vm);
        n_checks++;
        if (vm !== 4'b0100) begin
            n_fail++; $display("FAIL invalid_1011: vm=%b, required 0100", vm);
        end
        query(4'd3, 4'b0000, vv, vm);
        n_checks++;
        if (vm !== 4'b0001) begin
            n_fail++; $display("FAIL invalid_0000: vm=%b, required 0001", vm);
        end
        query(4'd3, 4'b0111, vv, vm);
        n_checks++;
        if (vm !== 4'b1000) begin
            n_fail++; $display("FAIL invalid_0111: vm=%b, required 1000", vm);
        end
    endtask

    task automatic test_bad_touch_and_same_cycle();
        logic vv; logic [3:0] vm;
        touch(4'd1, 4'b0000);
        touch(4'd1, 4'b0110);
        query(4'd1, 4'b1111, vv, vm);
        n_checks++;
        if (vm !== 4'b0001) begin
            n_fail++; $display("FAIL bad_touch_ignored: vm=%b, required 0001", vm);
        end
        @(negedge clk);
        t_valid = 1'b1; t_set = 4'd1; t_mask = 4'b0001;
        q_valid = 1'b1; q_set = 4'd1; q_bits = 4'b1111;
        @(posedge clk); #1;
        t_valid = 1'b0; q_valid = 1'b0;
        n_checks++;
        if (victim_mask !== 4'b0001) begin
            n_fail++; $display("FAIL same_cycle_pre_touch: vm=%b, required 0001", victim_mask);
        end
        query(4'd1, 4'b1111, vv, vm);
        n_checks++;
        if (vm !== 4'b0100) begin
            n_fail++; $display("FAIL same_cycle_touch_commit: vm=%b, required 0100", vm);
        end
    endtask

    task automatic test_flush();
        logic vv; logic [3:0] vm;
        int busy_cnt;
        int guard;
        int bad_sets;
        touch(4'd7, 4'b0001);
        touch(4'd15, 4'b0010);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            busy_cnt++; guard++;
            @(negedge clk);
            if (busy_cnt == 3) begin
                t_valid = 1'b1; t_set = 4'd0; t_mask = 4'b0001;
                q_valid = 1'b1; q_set = 4'd0; q_bits = 4'b1111;
            end
            if (busy_cnt == 5) flush = 1'b1;
            @(posedge clk); #1;
            if (busy_cnt == 3) begin
                n_checks++;
                if (victim_valid !== 1'b0) begin
                    n_fail++; $display("FAIL flush_query_dropped: vv=%b, required 0", victim_valid);
                end
            end
            t_valid = 1'b0; q_valid = 1'b0; flush = 1'b0;
        end
        n_checks++;
        if (busy_cnt != 16) begin
            n_fail++; $display("FAIL flush_busy_length: busy cycles=%0d, required 16", busy_cnt);
        end
        bad_sets = 0;
        for (int s = 0; s < 16; s++) begin
            query(4'(s), 4'b1111, vv, vm);
            if (vv !== 1'b1 || vm !== 4'b0001) bad_sets++;
        end
        n_checks++;
        if (bad_sets != 0) begin
            n_fail++; $display("FAIL flush_all_sets_cleared: sets not 0001=%0d, required 0", bad_sets);
        end
    endtask

    task automatic test_reset_mid_flush();
        logic vv; logic [3:0] vm;
        touch(4'd9, 4'b0001);
        @(negedge clk);
        flush = 1'b1;
        q_valid = 1'b1; q_set = 4'd9; q_bits = 4'b1111;
        @(posedge clk); #1;
        flush = 1'b0; q_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || victim_valid !== 1'b1 || victim_mask !== 4'b0100) begin
            n_fail++;
            $display("FAIL flush_with_query: busy=%b vv=%b vm=%b, required 1 1 0100", busy, victim_valid, victim_mask);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || victim_valid !== 1'b0 || victim_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_abort: busy=%b vv=%b vm=%b, required 0 0 0000", busy, victim_valid, victim_mask);
        end
        @(negedge clk);
        rst = 1'b0;
        query(4'd9, 4'b1111, vv, vm);
        n_checks++;
        if (vv !== 1'b1 || vm !== 4'b0001) begin
            n_fail++; $display("FAIL after_reset_query: vv=%b vm=%b, required 1 0001", vv, vm);
        end
    endtask

    initial begin
        rst = 1'b1;
        q_valid = 1'b0; q_set = '0; q_bits = '0;
        t_valid = 1'b0; t_set = '0; t_mask = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_tree_walk();
        test_invalid_first();
        test_bad_touch_and_same_cycle();
        test_flush();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/plru_replacement_unit.md
# plru_replacement_unit

Parametrised, stateful successor to the combinational replacement-mask logic. It keeps a tree pseudo-LRU state vector per cache set and updates it on every hit/fill touch. On a query it returns a one-hot victim way, preferring any invalid way. It sits between the tag/status-array lookup and the fill controller of the instruction cache, and supports a multi-cycle flush that clears all replacement state.

## Interface
- NUM_WAYS, 4, associativity; power of two, 2..16; tree holds NUM_WAYS-1 bits per set
- NUM_SETS, 16, number of sets; power of two, ≥2; SET_IDX_WIDTH = clog2(NUM_SETS) is a derived localparam
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_query_valid  input  1  victim request this cycle
- i_query_set  input  SET_IDX_WIDTH  set being queried
- i_query_valid_bits  input  NUM_WAYS  per-way valid bits of that set from the status array
- o_victim_mask  output  NUM_WAYS  one-hot victim way; all-zero when o_victim_valid=0
- o_victim_valid  output  1  o_victim_mask is valid
- i_touch_valid  input  1  access/fill update this cycle
- i_touch_set  input  SET_IDX_WIDTH  set being touched
- i_touch_way_mask  input  NUM_WAYS  one-hot way being touched
- i_flush  input  1  single-cycle request to clear all replacement state
- o_busy  output  1  flush sweep in progress

## Operation
- Tree encoding: node 0 is the root; node n has children 2n+1 (lower-index half) and 2n+2 (upper half). A node bit of 0 points the victim to the lower half and 1 to the upper half. Leaves map to ways 0..NUM_WAYS-1 in order.
- Victim select: if i_query_valid_bits != all-ones, the victim is the lowest-index way whose valid bit is 0. Otherwise walk from the root following the node bits of i_query_set to a leaf.
- A query never modifies state. The fill controller must touch the filled way.
- Touch: for each node on the path to the touched way, write the bit to point away from that way (0 if the way is in the upper half, 1 if in the lower half). Nodes off the path are unchanged.
- Touch with a zero mask or a mask with more than one bit set: no state change.
- Same-cycle query and touch to the same set: the query uses the pre-touch state. The touch still commits.
- FSM states:
  - IDLE: i_flush=1 → FLUSH, counter=0.
  - FLUSH: clear the tree bits of set[counter], increment counter. After clearing set NUM_SETS-1 → IDLE.
- While in FLUSH:
  - touches are dropped.
  - queries are dropped (o_victim_valid stays 0).
  - i_flush is ignored.
- i_flush in IDLE in the same cycle as a touch or query: the flush takes effect. The touch commits and the query is answered normally, because both are sampled in IDLE.

## Timing
- Reset (asynchronous): all tree bits 0, FSM=IDLE, counter=0, o_victim_valid=0, o_victim_mask=0, o_busy=0. Reset asserted mid-flush aborts the flush immediately.
- Query latency is 1 cycle. A query sampled at edge k drives o_victim_valid/o_victim_mask in the cycle after edge k. With no new query they return to 0 after the next edge. Back-to-back queries give a throughput of 1/cycle.
- A touch sampled at edge k is visible to a query sampled at edge k+1 or later.
- o_busy is 1 for exactly NUM_SETS cycles, starting the cycle after the edge that sampled i_flush. Requests sampled at the edge where o_busy falls are accepted.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then query set 0 with valid_bits=4'b1111 → one cycle later o_victim_valid=1, o_victim_mask=4'b0001.
- Set 3: touch ways 0, 2, 1 on consecutive cycles, then query with valid_bits=4'b1111 → o_victim_mask=4'b1000. A query on set 4 → 4'b0001 (sets are independent).
- Query with valid_bits=4'b1011 after arbitrary touches → 4'b0100. valid_bits=4'b0000 → 4'b0001.
- Touch masks 4'b0000 and 4'b0110 on set 1, then query → 4'b0001 (no update). Same-cycle touch way 0 and query on set 1 → 4'b0001; the next query → 4'b0100.
- Touch several sets, pulse i_flush → o_busy high for 16 cycles. Touches and queries are dropped meanwhile (o_victim_valid=0). A flush pulse during busy does not extend it. Afterwards every set returns 4'b0001.
- Assert i_rst mid-flush → o_busy=0 and o_victim_valid=0 immediately. After release, the first query → 4'b0001.
